// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller, signed or unsigned N-bit operands, 2N-bit product.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips straight to DONE with a zero product.
module mult_seq_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, ABS, MUL, SIGN, DONE} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   a_r, b_r;
    logic           sgn_r, neg_r;
    logic [N:0]     maga, magb;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;

    // One extra magnitude bit keeps |-2^(N-1)| = 2^(N-1) representable.
    function automatic logic [N:0] abs_mag(input logic [N-1:0] v, input logic s);
        if (s && v[N-1])
            return ~{1'b1, v} + (N+1)'(1);
        return {1'b0, v};
    endfunction

    function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] v, input logic n);
        return n ? (~v + (2*N)'(1)) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MULT_ZERO_BYPASS_EN
                    state_nxt = ((a == '0) || (b == '0)) ? DONE : ABS;
`else
                    state_nxt = ABS;
`endif
                end
            end
            ABS: begin
                busy      = 1'b1;
                state_nxt = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (cnt == LAST)
                    state_nxt = SIGN;
            end
            SIGN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // magb is consumed LSB-first by shifting, so its bit 0 is always the current multiplier bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sgn_r   <= 1'b0;
            neg_r   <= 1'b0;
            maga    <= '0;
            magb    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sgn_r <= sgn;
                        neg_r <= sgn & (a[N-1] ^ b[N-1]);
`ifdef MULT_ZERO_BYPASS_EN
                        if ((a == '0) || (b == '0))
                            product <= '0;
`endif
                    end
                end
                ABS: begin
                    maga <= abs_mag(a_r, sgn_r);
                    magb <= abs_mag(b_r, sgn_r);
                    acc  <= '0;
                    cnt  <= '0;
                end
                MUL: begin
                    if (magb[0])
                        acc <= acc + ({{(N-1){1'b0}}, maga} << cnt);
                    magb <= magb >> 1;
                    cnt  <= cnt + CW'(1);
                end
                SIGN: begin
                    product <= apply_sign(acc, neg_r);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl (N=4): cycle-level reference model plus directed literal cases.
module tb_mult_seq_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [2*N-1:0] product;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    mult_seq_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic logic [2*N-1:0] ref_mul(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
        int xv, yv;
        if (s) begin
            xv = int'($signed(x));
            yv = int'($signed(y));
        end else begin
            xv = int'(x);
            yv = int'(y);
        end
        return (2*N)'(xv * yv);
    endfunction

    // Reference: m_cyc counts edges since acceptance (-1 when idle).
    int             m_cyc = -1;
    logic [2*N-1:0] m_prod = '0;
    logic [2*N-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc  = -1;
            m_prod = '0;
        end else if (m_cyc < 0) begin
            if (start) begin
                m_pend = ref_mul(sgn, a, b);
                m_cyc  = 0;
                if (BYP && (a == '0 || b == '0)) begin
                    m_cyc  = N + 2;
                    m_prod = '0;
                end
            end
        end else begin
            m_cyc++;
            if (m_cyc == N + 2)
                m_prod = m_pend;
            else if (m_cyc == N + 3)
                m_cyc = -1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", 32'(busy), 32'(m_cyc >= 0 && m_cyc <= N + 1));
            chk("model_done", 32'(done), 32'(m_cyc == N + 2));
            chk("model_product", 32'(product), 32'(m_prod));
        end
    end

    task automatic do_op(input logic s, input logic [N-1:0] ia, input logic [N-1:0] ib,
                         input logic [2*N-1:0] exp, input string nm);
        int  n;
        bit  zr;
        zr = BYP && (ia == '0 || ib == '0);
        @(negedge clk);
        start = 1'b1; sgn = s; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy_after_accept"}, 32'(busy), 32'(!zr));
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), zr ? 32'd0 : 32'(N + 2));
        chk({nm, "_product"}, 32'(product), 32'(exp));
        @(negedge clk);
        chk({nm, "_done_low_after"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        bit saw_done;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_product", 32'(product), 32'd0);

        do_op(1'b1, 4'd3, 4'd5, 8'h0F, "s_3x5");
        do_op(1'b1, 4'b1000, 4'b1000, 8'h40, "s_m8xm8");
        do_op(1'b1, 4'b1000, 4'd7, 8'hC8, "s_m8x7");
        do_op(1'b1, 4'hF, 4'd0, 8'h00, "s_m1x0");
        do_op(1'b0, 4'd15, 4'd15, 8'hE1, "u_15x15");
        do_op(1'b0, 4'b1000, 4'd2, 8'h10, "u_8x2");

        // Start held high through the whole operation with different operands.
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 4'd2; b = 4'd3;
        @(negedge clk);
        a = 4'd7; b = 4'd7;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_product", 32'(product), 32'h06);
        @(negedge clk);
        start = 1'b0;
        chk("hold_start_in_done_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_product_kept", 32'(product), 32'h06);

        // Reset on the third MUL edge.
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 4'd5; b = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_product", 32'(product), 32'd0);
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("rst_mid_no_done", 32'(saw_done), 32'd0);
        do_op(1'b1, 4'd2, 4'hE, 8'hFC, "s_2xm2");

        do_op(1'b1, 4'd0, 4'hD, 8'h00, "zero_0xm3");

        // Randomized traffic, including start glitches during busy and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 2) == 0);
            sgn   = 1'($urandom);
            a     = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            b     = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
